// File: rtl/down_timer_if.sv
// Load handshake between a requester (master) and the down_timer (slave).
// The timer raises load_ready only while it can accept a new start value.
interface down_timer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter timer with an is_one pre-terminal flag, a one-cycle done
// pulse and optional auto-reload for periodic tick generation.
module down_timer #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  down_timer_if.slave      ld,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             done,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_value;

  assign ld.load_ready = (state == IDLE) && !abort;
  assign busy          = (state == RUN);

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let later statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the reload register is cleared too, so a stale period can never
      // leak into a later auto-reload.
      state        <= IDLE;
      count        <= '0;
      is_one       <= 1'b0;
      done         <= 1'b0;
      reload_value <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld.load_valid && ld.load_ready) begin
            count <= ld.load_value;
            if (ld.load_value == '0) begin
              // Zero load is a degenerate timer: expire immediately.
              is_one <= 1'b0;
              done   <= 1'b1;
            end else begin
              reload_value <= ld.load_value;
              is_one       <= (ld.load_value == ONE);
              state        <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state  <= IDLE;
            count  <= '0;
            is_one <= 1'b0;
          end else if (enable) begin
            if (count == ONE) begin
              done <= 1'b1;
              if (AUTO_RELOAD) begin
                count  <= reload_value;
                is_one <= (reload_value == ONE);
              end else begin
                count  <= '0;
                is_one <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              // is_one follows the next value so it stays aligned with count.
              count  <= count - ONE;
              is_one <= (count == WIDTH'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
